// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one sample per handshake, then a single MAC walks all
// taps of a circular delay line. y is updated with a one-cycle out_valid pulse.
module fir_mac_sequencer #(
  parameter int NTAPS = 8,
  parameter int XW    = 12,
  parameter int CW    = 12,
  parameter int YW    = 32,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [XW-1:0] x,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 coef_err,
  output logic                 busy,
  output logic                 out_valid,
  output logic signed [YW-1:0] y
);

  typedef enum logic {S_IDLE, S_MAC} state_t;

  state_t                r_state, w_next;
  logic signed [CW-1:0]  r_coef  [NTAPS];
  logic signed [XW-1:0]  r_delay [NTAPS];
  logic [AW-1:0]         r_wr_ptr, r_newest, r_k;
  logic signed [YW-1:0]  r_acc, r_y;
  logic                  r_out_valid, r_coef_err;

  logic                  w_idle, w_accept, w_last;
  logic [AW-1:0]         w_tap_idx;
  logic signed [XW+CW-1:0] w_prod;
  logic signed [YW-1:0]  w_prod_ext, w_sum;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = in_valid && w_idle;
  assign w_last    = (r_state == S_MAC) && (r_k == AW'(NTAPS-1));
  // AW-bit subtraction gives the modulo-NTAPS wrap for free
  assign w_tap_idx = r_newest - r_k;
  assign w_prod    = r_delay[w_tap_idx] * r_coef[r_k];
  assign w_prod_ext = {{(YW-XW-CW){w_prod[XW+CW-1]}}, w_prod};
  assign w_sum     = r_acc + w_prod_ext;

  assign in_ready  = w_idle;
  assign busy      = (r_state == S_MAC);
  assign out_valid = r_out_valid;
  assign coef_err  = r_coef_err;
  assign y         = r_y;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_MAC;
      S_MAC:   if (w_last)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A write landing on the accept edge is visible to the MAC that follows
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NTAPS; i++) r_coef[i] <= '0;
    end else if (coef_we && w_idle) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NTAPS; i++) r_delay[i] <= '0;
    end else if (w_accept) begin
      r_delay[r_wr_ptr] <= x;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wr_ptr    <= '0;
      r_newest    <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_coef_err  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_coef_err  <= coef_we && (r_state == S_MAC);
      if (w_accept) begin
        r_newest <= r_wr_ptr;
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_acc    <= '0;
        r_k      <= '0;
      end else if (r_state == S_MAC) begin
        r_acc <= w_sum;
        r_k   <= r_k + 1'b1;
        if (w_last) begin
          r_y         <= w_sum;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed + randomized bench for fir_mac_sequencer against a tap-history model.
module tb_fir_mac_sequencer;
  localparam int NTAPS = 8, XW = 12, CW = 12, YW = 32, AW = 3;

  logic                 clk = 1'b0;
  logic                 nreset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [XW-1:0] x;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 coef_err;
  logic                 busy;
  logic                 out_valid;
  logic signed [YW-1:0] y;

  int n_cmp = 0;
  int n_bad = 0;
  int m_coef [NTAPS];
  int m_hist [NTAPS];   // m_hist[0] is the newest accepted sample

  always #5 clk = ~clk;

  fir_mac_sequencer #(.NTAPS(NTAPS), .XW(XW), .CW(CW), .YW(YW), .AW(AW)) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(coef_err), .busy(busy), .out_valid(out_valid), .y(y)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_y();
    longint s = 0;
    for (int k = 0; k < NTAPS; k++) s += longint'(m_coef[k]) * longint'(m_hist[k]);
    return int'(s);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NTAPS; k++) begin m_coef[k] = 0; m_hist[k] = 0; end
  endtask

  // Called one step after a rising edge; reset is asserted asynchronously.
  task automatic do_reset(input string tag);
    nreset = 1'b0;
    #1;
    chk({tag, ".y"}, y, 0);
    chk({tag, ".ov"}, out_valid, 0);
    chk({tag, ".busy"}, busy, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    chk({tag, ".rdy"}, in_ready, 1);
  endtask

  task automatic wr_coef(input int addr, input int data);
    coef_we = 1'b1; coef_addr = addr[AW-1:0]; coef_data = data[CW-1:0];
    @(posedge clk); #1;
    coef_we = 1'b0;
    m_coef[addr] = data;
  endtask

  // bw_at>0 issues a coefficient write (addr 0, data 100) before MAC edge bw_at
  task automatic run_sample(input int xv, input bit keep, input int bw_at,
                            input bit sim_we, input int sim_addr, input int sim_data,
                            input string tag);
    int want;
    chk({tag, ".rdy"}, in_ready, 1);
    in_valid = 1'b1; x = xv[XW-1:0];
    if (sim_we) begin coef_we = 1'b1; coef_addr = sim_addr[AW-1:0]; coef_data = sim_data[CW-1:0]; end
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
    coef_we = 1'b0;
    if (sim_we) m_coef[sim_addr] = sim_data;
    for (int k = NTAPS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = xv;
    want = model_y();
    chk({tag, ".busy"}, busy, 1);
    for (int i = 1; i <= NTAPS; i++) begin
      if (i == bw_at) begin coef_we = 1'b1; coef_addr = '0; coef_data = 12'sd100; end
      @(posedge clk); #1;
      coef_we = 1'b0;
      if (bw_at > 0) chk({tag, ".err"}, coef_err, (i == bw_at) ? 1 : 0);
      if (i < NTAPS) begin
        chk({tag, ".ov"}, out_valid, 0);
        chk({tag, ".nrdy"}, in_ready, 0);
      end else begin
        chk({tag, ".ov"}, out_valid, 1);
        chk({tag, ".y"}, y, want);
      end
    end
  endtask

  initial begin
    nreset = 1'b0; in_valid = 1'b0; x = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_clear();
    #1;
    chk("rst.y", y, 0);
    chk("rst.ov", out_valid, 0);
    chk("rst.err", coef_err, 0);
    chk("rst.busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    chk("rst.rdy", in_ready, 1);

    // Impulse response walks the coefficients out in order
    for (int k = 0; k < NTAPS; k++) wr_coef(k, k + 1);
    run_sample(1, 0, 0, 0, 0, 0, "imp");
    for (int n = 1; n < NTAPS; n++) run_sample(0, 0, 0, 0, 0, 0, "imp");
    run_sample(0, 0, 0, 0, 0, 0, "imp9");

    // Sign/width extremes
    do_reset("rst2");
    wr_coef(0, -2048);
    run_sample(-2048, 0, 0, 0, 0, 0, "ext.neg");
    run_sample(2047, 0, 0, 0, 0, 0, "ext.pos");

    // Back-to-back with in_valid held high
    do_reset("rst3");
    for (int k = 0; k < NTAPS; k++) wr_coef(k, 1);
    run_sample(12, 1, 0, 0, 0, 0, "b2b");
    run_sample(-5, 1, 0, 0, 0, 0, "b2b");
    run_sample(7, 1, 0, 0, 0, 0, "b2b");
    run_sample(-3, 0, 0, 0, 0, 0, "b2b");

    // Busy write is dropped; the same write in IDLE takes effect
    run_sample(4, 0, 3, 0, 0, 0, "bwr");
    wr_coef(0, 100);
    run_sample(2, 0, 0, 0, 0, 0, "bwr.idle");

    // Simultaneous write and accept
    do_reset("rst4");
    run_sample(5, 0, 0, 1, 0, 3, "sim");

    // Reset during MAC discards the partial result
    do_reset("rst5");
    for (int k = 0; k < NTAPS; k++) wr_coef(k, 1);
    run_sample(100, 0, 0, 0, 0, 0, "pre");
    in_valid = 1'b1; x = 12'sd50;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    do_reset("midrst");
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("midrst.ov", out_valid, 0);
      chk("midrst.rdy", in_ready, 1);
    end
    run_sample(1, 0, 0, 0, 0, 0, "post");

    // Randomized: random coefficient rewrites, samples and busy writes
    for (int n = 0; n < 40; n++) begin
      int nw, xv;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++)
        wr_coef($urandom_range(0, NTAPS-1), int'($urandom_range(0, 4095)) - 2048);
      xv = int'($urandom_range(0, 4095)) - 2048;
      if ($urandom_range(0, 3) == 0)
        run_sample(xv, 0, $urandom_range(1, NTAPS), 0, 0, 0, "rnd.bw");
      else if ($urandom_range(0, 3) == 0)
        run_sample(xv, 0, 0, 1, $urandom_range(0, NTAPS-1), int'($urandom_range(0, 4095)) - 2048, "rnd.sim");
      else
        run_sample(xv, 0, 0, 0, 0, 0, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
